// File: rtl/ebpf_pkg.sv
// ebpf_pkg: shared opcodes, jump class codes, sequencer state and next-PC mode encodings
package ebpf_pkg;

    localparam logic [7:0] OP_LDDW = 8'h18;
    localparam logic [7:0] OP_JA   = 8'h05;
    localparam logic [7:0] OP_CALL = 8'h85;
    localparam logic [7:0] OP_EXIT = 8'h95;

    localparam logic [2:0] CLS_JMP   = 3'h5;
    localparam logic [2:0] CLS_JMP32 = 3'h6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FETCH_HI,
        ST_ISSUE,
        ST_RESOLVE,
        ST_HALT,
        ST_FAULT
    } pc_state_e;

    // Next-PC selection: one slot, two slots (LDDW), or one slot plus jump offset
    typedef enum logic [1:0] {
        NP_SEQ,
        NP_DBL,
        NP_OFF
    } np_mode_e;

endpackage

// File: rtl/ebpf_pc_sequencer_if.sv
// ebpf_pc_sequencer_if: fetch, issue and branch-resolve bundle between the sequencer and memory/execute
//   fetch_req/fetch_addr  -> memory, fetch_ack/fetch_data <- memory
//   issue_valid/issue_insn/issue_imm_hi -> execute, issue_ready <- execute
//   br_resolve/br_taken   <- execute
//   master: sequencer side, slave: memory/execute side
interface ebpf_pc_sequencer_if #(
    parameter int PC_W = 64
);
    logic            fetch_req;
    logic [PC_W-1:0] fetch_addr;
    logic            fetch_ack;
    logic [63:0]     fetch_data;
    logic            issue_valid;
    logic [63:0]     issue_insn;
    logic [31:0]     issue_imm_hi;
    logic            issue_ready;
    logic            br_resolve;
    logic            br_taken;

    modport master (
        output fetch_req, fetch_addr, issue_valid, issue_insn, issue_imm_hi,
        input  fetch_ack, fetch_data, issue_ready, br_resolve, br_taken
    );

    modport slave (
        input  fetch_req, fetch_addr, issue_valid, issue_insn, issue_imm_hi,
        output fetch_ack, fetch_data, issue_ready, br_resolve, br_taken
    );
endinterface

// File: rtl/ebpf_next_pc.sv
// ebpf_next_pc: combinational next-PC adder
//   pc_i      current instruction address
//   off_i     signed 16-bit jump offset in slots
//   mode_i    NP_SEQ: pc+8, NP_DBL: pc+16, NP_OFF: pc+8+sext(off)*8
//   next_pc_o result, modulo 2^PC_W
module ebpf_next_pc
    import ebpf_pkg::*;
#(
    parameter int PC_W       = 64,
    parameter int INSN_BYTES = 8
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [15:0]     off_i,
    input  np_mode_e        mode_i,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] step;
    logic [PC_W-1:0] sext;

    assign step = PC_W'(INSN_BYTES);
    assign sext = {{(PC_W-16){off_i[15]}}, off_i};
    assign next_pc_o = pc_i + step + (mode_i == NP_DBL ? step : mode_i == NP_OFF ? (sext << 3) : '0);

endmodule

// File: rtl/ebpf_pc_sequencer.sv
// ebpf_pc_sequencer: eBPF program counter, sequences fetch -> issue -> resolve and halts on EXIT
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i, start_pc_i   begin a run at start_pc_i (only when idle, halted or faulted)
//   prog_len_i            program size in bytes, used only by the bounds check
//   bus (master)          fetch, issue and branch-resolve handshakes
//   pc_o                  address of the instruction in flight
//   busy_o, halted_o      running / EXIT retired
//   fault_o               out-of-bounds or misaligned fetch address
// Optional feature: define PC_BOUNDS_CHECK_EN to check every fetch address against prog_len_i.
module ebpf_pc_sequencer
    import ebpf_pkg::*;
#(
    parameter int PC_W       = 64,
    parameter int INSN_BYTES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [PC_W-1:0]     start_pc_i,
    input  logic [PC_W-1:0]     prog_len_i,
    ebpf_pc_sequencer_if.master bus,
    output logic [PC_W-1:0]     pc_o,
    output logic                busy_o,
    output logic                halted_o,
    output logic                fault_o
);

    pc_state_e       state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] hi_addr;
    logic            halted_q;
    logic            fault_q;
    logic            idle;
    logic            is_br;
    logic            launch;
    logic            bad_tgt;
    logic            bad_hi;
    logic [7:0]      op;
    np_mode_e        mode;

    assign op      = bus.issue_insn[7:0];
    assign idle    = state_q inside {ST_IDLE, ST_HALT, ST_FAULT};
    assign is_br   = (op[2:0] == CLS_JMP || op[2:0] == CLS_JMP32) && !(op inside {OP_JA, OP_CALL, OP_EXIT});
    assign mode    = state_q == ST_RESOLVE ? (bus.br_taken ? NP_OFF : NP_SEQ) :
                     op == OP_LDDW ? NP_DBL : op == OP_JA ? NP_OFF : NP_SEQ;
    assign tgt     = idle ? start_pc_i : pc_d;
    assign hi_addr = pc_q + PC_W'(INSN_BYTES);

    // Every path that leaves for a fresh fetch (start, plain accept, branch resolution) funnels through launch
    assign launch  = idle ? start_i :
                     state_q == ST_ISSUE ? bus.issue_ready && op != OP_EXIT && !is_br :
                     state_q == ST_RESOLVE && bus.br_resolve;

    ebpf_next_pc #(.PC_W(PC_W), .INSN_BYTES(INSN_BYTES)) u_next_pc (
        .pc_i      (pc_q),
        .off_i     (bus.issue_insn[31:16]),
        .mode_i    (mode),
        .next_pc_o (pc_d)
    );

`ifdef PC_BOUNDS_CHECK_EN
    localparam int AW = PC_W + 1;

    // Extra top bit keeps addr+8 from wrapping past prog_len
    function automatic logic oob(input logic [PC_W-1:0] a);
        return {1'b0, a} + AW'(INSN_BYTES) > {1'b0, prog_len_i} || a[2:0] != 3'd0;
    endfunction

    assign bad_tgt = oob(tgt);
    assign bad_hi  = oob(hi_addr);
`else
    logic unused_prog_len;

    assign bad_tgt = 1'b0;
    assign bad_hi  = 1'b0;
    assign unused_prog_len = ^prog_len_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            pc_q             <= '0;
            halted_q         <= 1'b0;
            fault_q          <= 1'b0;
            bus.fetch_req    <= 1'b0;
            bus.fetch_addr   <= '0;
            bus.issue_valid  <= 1'b0;
            bus.issue_insn   <= '0;
            bus.issue_imm_hi <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.fetch_ack) begin
                        bus.issue_insn <= bus.fetch_data;
                        if (bus.fetch_data[7:0] == OP_LDDW) begin
                            state_q        <= bad_hi ? ST_FAULT : ST_FETCH_HI;
                            fault_q        <= bad_hi;
                            bus.fetch_req  <= !bad_hi;
                            bus.fetch_addr <= hi_addr;
                        end else begin
                            state_q          <= ST_ISSUE;
                            bus.fetch_req    <= 1'b0;
                            bus.issue_imm_hi <= '0;
                            bus.issue_valid  <= 1'b1;
                        end
                    end
                end
                ST_FETCH_HI: begin
                    if (bus.fetch_ack) begin
                        state_q          <= ST_ISSUE;
                        bus.fetch_req    <= 1'b0;
                        bus.issue_imm_hi <= bus.fetch_data[63:32];
                        bus.issue_valid  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // Plain instructions are redirected to FETCH by the launch block below
                    if (bus.issue_ready) begin
                        bus.issue_valid <= 1'b0;
                        state_q         <= op == OP_EXIT ? ST_HALT : ST_RESOLVE;
                        halted_q        <= op == OP_EXIT;
                    end
                end
                default: ;
            endcase
            if (launch) begin
                state_q        <= bad_tgt ? ST_FAULT : ST_FETCH;
                pc_q           <= tgt;
                halted_q       <= 1'b0;
                fault_q        <= bad_tgt;
                bus.fetch_req  <= !bad_tgt;
                bus.fetch_addr <= tgt;
            end
        end
    end

    assign pc_o     = pc_q;
    assign busy_o   = !idle;
    assign halted_o = halted_q;
    assign fault_o  = fault_q;

endmodule

// File: tb/tb_ebpf_pc_sequencer.sv
// tb_ebpf_pc_sequencer: directed self-checking bench for ebpf_pc_sequencer
module tb_ebpf_pc_sequencer;

    localparam logic [63:0] ALU   = 64'h0000_0001_0000_0007;
    localparam logic [63:0] EXIT  = 64'h0000_0000_0000_0095;
    localparam logic [63:0] JA_M2 = 64'h0000_0000_FFFE_0005;
    localparam logic [63:0] JA_MX = 64'h0000_0000_7FFF_0005;
    localparam logic [63:0] JEQ3  = 64'h0000_0000_0003_0015;
    localparam logic [63:0] LDDW  = 64'h1234_5678_0000_0018;
    localparam logic [63:0] LDHI  = 64'hDEAD_BEEF_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] start_pc = '0;
    logic [63:0] prog_len = 64'h1000;
    logic [63:0] pc;
    logic        busy;
    logic        halted;
    logic        fault;
    int          n_chk = 0;
    int          n_fail = 0;

    ebpf_pc_sequencer_if #(.PC_W(64)) bus();

    ebpf_pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .start_pc_i (start_pc),
        .prog_len_i (prog_len),
        .bus        (bus),
        .pc_o       (pc),
        .busy_o     (busy),
        .halted_o   (halted),
        .fault_o    (fault)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        bus.fetch_ack = 1'b0;
        bus.issue_ready = 1'b0;
        bus.br_resolve = 1'b0;
        bus.br_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic go(input logic [63:0] a);
        start_pc = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req(output logic [63:0] a, output bit ok);
        ok = bus.fetch_req;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.fetch_req;
        end
        a = bus.fetch_addr;
    endtask

    task automatic serve(input logic [63:0] d, output logic [63:0] a, output bit ok);
        wait_req(a, ok);
        if (ok) begin
            bus.fetch_ack = 1'b1;
            bus.fetch_data = d;
            @(negedge clk);
            bus.fetch_ack = 1'b0;
        end
    endtask

    task automatic take(output logic [63:0] insn, output logic [31:0] hi, output bit ok);
        ok = bus.issue_valid;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.issue_valid;
        end
        insn = bus.issue_insn;
        hi = bus.issue_imm_hi;
        if (ok) begin
            bus.issue_ready = 1'b1;
            @(negedge clk);
            bus.issue_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_chk++;
        if ({bus.fetch_req, bus.issue_valid, busy, halted, fault} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {bus.fetch_req, bus.issue_valid, busy, halted, fault});
        end
        n_chk++;
        if (pc !== 64'h0 || bus.fetch_addr !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_pc_addr: got pc=%h addr=%h want 0/0", pc, bus.fetch_addr);
        end
        n_chk++;
        if (bus.issue_insn !== 64'h0 || bus.issue_imm_hi !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_issue: got insn=%h hi=%h want 0/0", bus.issue_insn, bus.issue_imm_hi);
        end
    endtask

    task automatic test_sequential;
        logic [63:0] prog [3];
        logic [63:0] a;
        logic [63:0] insn;
        logic [31:0] hi;
        bit ok;
        prog = '{ALU, ALU, EXIT};
        go(64'h100);
        for (int i = 0; i < 3; i++) begin
            serve(prog[i], a, ok);
            n_chk++;
            if (!ok || a !== 64'h100 + 64'(8 * i)) begin
                n_fail++;
                $display("FAIL seq_fetch%0d: got ok=%0d addr=%h want addr=%h", i, ok, a, 64'h100 + 64'(8 * i));
            end
            take(insn, hi, ok);
            n_chk++;
            if (!ok || insn !== prog[i] || hi !== 32'h0) begin
                n_fail++;
                $display("FAIL seq_issue%0d: got ok=%0d insn=%h hi=%h want insn=%h hi=0", i, ok, insn, hi, prog[i]);
            end
        end
        n_chk++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 64'h110) begin
            n_fail++;
            $display("FAIL seq_halt: got halted=%b busy=%b pc=%h want 1/0/110", halted, busy, pc);
        end
    endtask

    task automatic test_ja;
        logic [63:0] a;
        logic [63:0] insn;
        logic [31:0] hi;
        bit ok;
        do_reset();
        go(64'h200);
        serve(JA_M2, a, ok);
        take(insn, hi, ok);
        wait_req(a, ok);
        n_chk++;
        if (!ok || a !== 64'h1F8) begin
            n_fail++;
            $display("FAIL ja_back: got ok=%0d addr=%h want 1f8", ok, a);
        end
        do_reset();
        go(64'hFFFF_FFFF_FFFF_FFF8);
`ifdef PC_BOUNDS_CHECK_EN
        n_chk++;
        if (fault !== 1'b1 || bus.fetch_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ja_wrap_fault: got fault=%b req=%b want 1/0", fault, bus.fetch_req);
        end
`else
        serve(JA_MX, a, ok);
        take(insn, hi, ok);
        wait_req(a, ok);
        n_chk++;
        if (!ok || a !== 64'h3FFF8) begin
            n_fail++;
            $display("FAIL ja_wrap: got ok=%0d addr=%h want 3fff8", ok, a);
        end
`endif
    endtask

    task automatic test_branch;
        logic [63:0] a;
        logic [63:0] insn;
        logic [31:0] hi;
        bit ok;
        do_reset();
        go(64'h40);
        serve(JEQ3, a, ok);
        take(insn, hi, ok);
        n_chk++;
        if (busy !== 1'b1 || bus.fetch_req !== 1'b0 || bus.issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL br_wait: got busy=%b req=%b valid=%b want 1/0/0", busy, bus.fetch_req, bus.issue_valid);
        end
        bus.br_resolve = 1'b1;
        bus.br_taken = 1'b1;
        @(negedge clk);
        bus.br_resolve = 1'b0;
        wait_req(a, ok);
        n_chk++;
        if (!ok || a !== 64'h60) begin
            n_fail++;
            $display("FAIL br_taken: got ok=%0d addr=%h want 60", ok, a);
        end
        do_reset();
        go(64'h40);
        bus.br_resolve = 1'b1;
        bus.br_taken = 1'b1;
        @(negedge clk);
        bus.br_resolve = 1'b0;
        bus.br_taken = 1'b0;
        n_chk++;
        if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 64'h40 || pc !== 64'h40) begin
            n_fail++;
            $display("FAIL br_spurious: got req=%b addr=%h pc=%h want 1/40/40", bus.fetch_req, bus.fetch_addr, pc);
        end
        serve(JEQ3, a, ok);
        take(insn, hi, ok);
        bus.br_resolve = 1'b1;
        @(negedge clk);
        bus.br_resolve = 1'b0;
        wait_req(a, ok);
        n_chk++;
        if (!ok || a !== 64'h48) begin
            n_fail++;
            $display("FAIL br_not_taken: got ok=%0d addr=%h want 48", ok, a);
        end
    endtask

    task automatic test_lddw;
        logic [63:0] a;
        logic [63:0] insn;
        logic [31:0] hi;
        bit ok;
        do_reset();
        go(64'h80);
        serve(LDDW, a, ok);
        n_chk++;
        if (!ok || a !== 64'h80) begin
            n_fail++;
            $display("FAIL lddw_lo: got ok=%0d addr=%h want 80", ok, a);
        end
        serve(LDHI, a, ok);
        n_chk++;
        if (!ok || a !== 64'h88) begin
            n_fail++;
            $display("FAIL lddw_hi: got ok=%0d addr=%h want 88", ok, a);
        end
        take(insn, hi, ok);
        n_chk++;
        if (!ok || insn !== LDDW || hi !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lddw_issue: got insn=%h hi=%h want %h/deadbeef", insn, hi, LDDW);
        end
        wait_req(a, ok);
        n_chk++;
        if (!ok || a !== 64'h90) begin
            n_fail++;
            $display("FAIL lddw_next: got ok=%0d addr=%h want 90", ok, a);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] a;
        logic [63:0] insn;
        logic [31:0] hi;
        bit ok;
        bit stable;
        do_reset();
        go(64'h300);
        wait_req(a, ok);
        stable = ok;
        repeat (5) begin
            @(negedge clk);
            if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 64'h300) stable = 1'b0;
        end
        n_chk++;
        if (!stable) begin
            n_fail++;
            $display("FAIL bp_fetch_hold: got req=%b addr=%h want 1/300", bus.fetch_req, bus.fetch_addr);
        end
        serve(ALU, a, ok);
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.issue_valid !== 1'b1 || bus.issue_insn !== ALU) stable = 1'b0;
        end
        n_chk++;
        if (!stable) begin
            n_fail++;
            $display("FAIL bp_issue_hold: got valid=%b insn=%h want 1/%h", bus.issue_valid, bus.issue_insn, ALU);
        end
        take(insn, hi, ok);
        wait_req(a, ok);
        n_chk++;
        if (!ok || a !== 64'h308) begin
            n_fail++;
            $display("FAIL bp_next: got ok=%0d addr=%h want 308", ok, a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.fetch_req, bus.issue_valid, busy, halted, fault} !== 5'b0 || pc !== 64'h0 || bus.fetch_addr !== 64'h0 || bus.issue_insn !== 64'h0) begin
            n_fail++;
            $display("FAIL bp_async_reset: got flags=%b pc=%h addr=%h insn=%h want 0", {bus.fetch_req, bus.issue_valid, busy, halted, fault}, pc, bus.fetch_addr, bus.issue_insn);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.fetch_ack = 1'b1;
        bus.fetch_data = ALU;
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.issue_valid !== 1'b0 || busy !== 1'b0 || bus.issue_insn !== 64'h0) begin
            n_fail++;
            $display("FAIL bp_stray_ack: got valid=%b busy=%b insn=%h want 0/0/0", bus.issue_valid, busy, bus.issue_insn);
        end
    endtask

    task automatic test_bounds;
        logic [63:0] a;
        logic [63:0] insn;
        logic [31:0] hi;
        bit ok;
        bit seen;
        do_reset();
        prog_len = 64'h18;
        go(64'h0);
        for (int i = 0; i < 3; i++) begin
            serve(ALU, a, ok);
            n_chk++;
            if (!ok || a !== 64'(8 * i)) begin
                n_fail++;
                $display("FAIL bounds_fetch%0d: got ok=%0d addr=%h want %h", i, ok, a, 64'(8 * i));
            end
            take(insn, hi, ok);
        end
`ifdef PC_BOUNDS_CHECK_EN
        seen = 1'b0;
        repeat (5) begin
            if (bus.fetch_req) seen = 1'b1;
            @(negedge clk);
        end
        n_chk++;
        if (seen || fault !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bounds_fault: got req_seen=%0d fault=%b busy=%b want 0/1/0", seen, fault, busy);
        end
`else
        seen = 1'b0;
        wait_req(a, ok);
        n_chk++;
        if (!ok || a !== 64'h18 || fault !== 1'b0 || seen) begin
            n_fail++;
            $display("FAIL bounds_off: got ok=%0d addr=%h fault=%b want addr=18 fault=0", ok, a, fault);
        end
`endif
        prog_len = 64'h1000;
    endtask

    initial begin
        bus.fetch_ack = 1'b0;
        bus.fetch_data = '0;
        bus.issue_ready = 1'b0;
        bus.br_resolve = 1'b0;
        bus.br_taken = 1'b0;
        test_reset();
        test_sequential();
        test_ja();
        test_branch();
        test_lddw();
        test_backpressure();
        test_bounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
